// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and occupancy logic for a dual-clock FIFO.
// Consumes the Gray read pointer already synchronized into clk and publishes a Gray write pointer.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wfill,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - AFULL_THRESH);

  // Handshake: winc is a request with no retry; it is accepted exactly when wen is high
  // (winc & ~wfull), and a request made while full is dropped and flagged in overflow.

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] wfill_q, wfill_d;
  logic                wfull_q, wfull_d;
  logic                walmost_full_q, walmost_full_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_WIDTH:0] rbin_s;
  logic [ADDR_WIDTH:0] full_ptr;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full_ptr = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

    wen            = winc & ~wfull_q;
    wbin_d         = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    wfull_d        = (wptr_d == full_ptr);
    wfill_d        = wbin_d - rbin_s;
    walmost_full_d = (wfill_d >= AFULL_LEVEL);
    overflow_d     = overflow_q | (winc & wfull_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfill_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfill_q        <= wfill_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      overflow_q     <= overflow_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wfill        = wfill_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (ADDR_WIDTH=4, AFULL_THRESH=2): vector table, corner sequences,
// and randomized traffic against a write/read-count model.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wfill;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr),
    .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full), .wfill(wfill), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       wen;
    logic       full;
    logic       afull;
    logic [4:0] fill;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  // Model: running totals of accepted writes and of reads seen by the write domain.
  int         m_w, m_r;
  logic       m_full, m_af, m_ovf;
  logic [4:0] m_fill;

  function automatic logic [4:0] gray(int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero_regs(string tag);
    chk({tag, "_wptr"}, 32'(wptr), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wfull"}, 32'(wfull), 0);
    chk({tag, "_afull"}, 32'(walmost_full), 0);
    chk({tag, "_wfill"}, 32'(wfill), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_wptr"}, 32'(wptr), 32'(gray(m_w)));
    chk({tag, "_waddr"}, 32'(waddr), 32'(m_w % 16));
    chk({tag, "_wfull"}, 32'(wfull), 32'(m_full));
    chk({tag, "_afull"}, 32'(walmost_full), 32'(m_af));
    chk({tag, "_wfill"}, 32'(wfill), 32'(m_fill));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_full = 0; m_af = 0; m_ovf = 0; m_fill = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    winc = 1'b1;
    wq2_rptr = '0;
    rst = 1'b0;
    #1;
    chk_zero_regs("rst_async");
    chk("rst_wen", 32'(wen), 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_zero_regs("rst_held");
    chk("rst_held_wen", 32'(wen), 1);
    rst = 1'b1;
    winc = 1'b0;
    model_reset();
  endtask

  task automatic model_edge(logic w);
    logic acc;
    acc   = w && !m_full;
    m_ovf = m_ovf | (w && m_full);
    m_w   = m_w + int'(acc);
    m_fill = 5'(m_w - m_r);
    m_full = (m_w - m_r) == 16;
    m_af   = (m_w - m_r) >= 14;
  endtask

  initial begin
    vec_t v;
    logic [4:0] prev;
    logic       seen31, seen0, any_full;
    int         hist[$];

    rst = 1'b1;
    winc = 1'b0;
    wq2_rptr = '0;

    // Fill, overflow and drain vectors; expected values are after the edge.
    for (int i = 1; i <= 16; i++) begin
      v = '{1'b1, 5'd0, 1'b1, (i == 16), (i >= 14), 5'(i), gray(i), 4'(i % 16), 1'b0};
      vecs.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 4'd0, 1'b1};
      vecs.push_back(v);
    end
    v = '{1'b0, 5'b00110, 1'b0, 1'b0, 1'b0, 5'd12, 5'b11000, 4'd0, 1'b1};
    vecs.push_back(v);
    v = '{1'b1, 5'b00110, 1'b1, 1'b0, 1'b0, 5'd13, 5'b11001, 4'd1, 1'b1};
    vecs.push_back(v);

    do_reset();
    foreach (vecs[k]) begin
      @(negedge clk);
      winc = vecs[k].winc;
      wq2_rptr = vecs[k].rptr;
      #1;
      chk($sformatf("vec%0d_wen", k), 32'(wen), 32'(vecs[k].wen));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wfull", k), 32'(wfull), 32'(vecs[k].full));
      chk($sformatf("vec%0d_afull", k), 32'(walmost_full), 32'(vecs[k].afull));
      chk($sformatf("vec%0d_wfill", k), 32'(wfill), 32'(vecs[k].fill));
      chk($sformatf("vec%0d_wptr", k), 32'(wptr), 32'(vecs[k].wptr));
      chk($sformatf("vec%0d_waddr", k), 32'(waddr), 32'(vecs[k].waddr));
      chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'(vecs[k].ovf));
    end

    // Wrap: 40 writes with the read pointer trailing two cycles behind.
    do_reset();
    prev = '0;
    seen31 = 0; seen0 = 0; any_full = 0;
    hist = {0, 0};
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      winc = 1'b1;
      wq2_rptr = gray(hist[0]);
      @(posedge clk);
      #1;
      hist.pop_front();
      hist.push_back(n + 1);
      chk($sformatf("wrap%0d_onebit", n), 32'($countones(wptr ^ prev)), 1);
      chk($sformatf("wrap%0d_wptr", n), 32'(wptr), 32'(gray(n + 1)));
      if (wptr == 5'b10000) seen31 = 1;
      if (seen31 && wptr == 5'b00000) seen0 = 1;
      if (wfull) any_full = 1;
      prev = wptr;
    end
    chk("wrap_seen31_then_0", 32'({seen31, seen0}), 32'b11);
    chk("wrap_never_full", 32'(any_full), 0);

    // Mid-operation reset with nine entries outstanding.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      winc = 1'b1;
      wq2_rptr = '0;
    end
    @(negedge clk);
    winc = 1'b1;
    chk("mid_fill9", 32'(wfill), 9);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_regs("mid_rst");
    chk("mid_rst_wen", 32'(wen), 1);
    @(negedge clk);
    rst = 1'b1;
    winc = 1'b0;
    model_reset();

    // Randomized traffic against the count model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk_model($sformatf("rnd%0d", c));
      if (m_r < m_w && $urandom_range(0, 2) == 0)
        m_r = m_r + int'($urandom_range(1, 32'(m_w - m_r)));
      wq2_rptr = gray(m_r);
      winc = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rnd%0d_wen", c), 32'(wen), 32'(winc && !m_full));
      @(posedge clk);
      model_edge(winc);
    end
    @(negedge clk);
    chk_model("rnd_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and full-flag generator for the dual-clock asynchronous FIFO. It sits directly downstream of the double-FF synchronizer that brings the Gray-coded read pointer into the write clock domain. It consumes that synchronized pointer and produces four things:
- the RAM write address and write enable;
- the registered Gray write pointer that is synchronized into the read domain;
- full / almost-full status;
- a sticky overflow flag.

## Interface
- ADDR_WIDTH, 4: FIFO address bits; depth DEPTH = 2^ADDR_WIDTH; must be ≥ 2.
- AFULL_THRESH, 2: `walmost_full` asserts when free slots ≤ AFULL_THRESH; range 1..DEPTH-1.

- clk  in  1  write-domain clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- winc  in  1  write request from producer.
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already double-FF synchronized into `clk`.
- wen  out  1  RAM write enable, combinational: `winc & ~wfull`.
- waddr  out  ADDR_WIDTH  RAM write address = low bits of binary write pointer.
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wfill  out  ADDR_WIDTH+1  registered conservative occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.

## Operation
- State:
  - `wbin`: binary pointer, ADDR_WIDTH+1 bits.
  - `wptr`: Gray pointer.
  - `wfull`, `walmost_full`, `wfill`, `overflow`.
- Next-state values:
  - `wbin_next = wbin + (winc & ~wfull)`, modulo 2^(ADDR_WIDTH+1).
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Each edge: `wbin <= wbin_next`, `wptr <= wgray_next`.
- Full detection:
  - Full condition: `wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}`.
  - `wfull` registers that condition on each edge.
- Occupancy:
  - `rbin_s` = Gray-to-binary of `wq2_rptr`, combinational.
  - `wfill <= wbin_next - rbin_s`, modulo 2^(ADDR_WIDTH+1).
  - `walmost_full <= (wbin_next - rbin_s) >= DEPTH - AFULL_THRESH`.
- Overflow: `overflow <= overflow | (winc & wfull)`. It is cleared only by reset.
- Write while full: pointer, address and `wptr` are held and `wen` = 0. The request is dropped, not queued.
- Reset: while `rst` = 0, all registers are 0 asynchronously. Resulting outputs: `wptr`=0, `waddr`=0, `wfull`=0, `walmost_full`=0, `wfill`=0, `overflow`=0, and `wen` = `winc`. Normal operation resumes on the first rising edge after `rst` returns to 1.
- Wrap-around: `wbin` and `wptr` roll from 2^(ADDR_WIDTH+1)-1 to 0 with no special handling. The MSB (lap bit) disambiguates full from empty.
- Simultaneous events:
  - A write and a `wq2_rptr` advance in the same cycle are both folded into the next-state computation.
  - `wfull` reflects the post-write pointer against the current synchronized read pointer.

## Timing
- Write latency: `wen`/`waddr` are valid in the request cycle. `wptr` updates on that same edge.
- `wfull` asserts on the same edge as the write that fills the last slot, so no extra write can slip through.
- Full deassert latency:
  - 2 `clk` cycles in the upstream synchronizer after the read-domain pointer change, then 1 edge here.
  - This is pessimistic only and never causes overflow of RAM.
- `walmost_full` and `wfill` share `wfull` timing. `wfill` may overstate occupancy, never understate it.
- `wptr` is a register output with exactly one bit changing per increment. It is safe to synchronize.

## Test plan
Parameters for all scenarios: ADDR_WIDTH=4, AFULL_THRESH=2.
- Reset: drive `rst`=0 with `winc`=1 → all registered outputs 0; `wen`=1; no pointer movement until `rst`=1.
- Fill: `wq2_rptr`=0, `winc`=1 for 16 cycles →
  - `walmost_full`=1 after the 14th write edge (`wfill`=14).
  - After the 16th edge: `wfull`=1, `wfill`=16, `wptr`=5'b11000, `waddr`=0.
- Overflow: keep `winc`=1 for 3 more cycles while full → `wen`=0, `wptr` stays 5'b11000, `overflow`=1 and stays 1 after `winc` drops.
- Drain: set `wq2_rptr`=5'b00110 (binary 4) → next edge `wfull`=0, `wfill`=12, `walmost_full`=0.
- Wrap: 40 writes with `wq2_rptr` following 2 cycles behind →
  - `wptr` passes 5'b10000 (binary 31) then 5'b00000.
  - Exactly one `wptr` bit toggles per write.
  - `wfull` never asserts.
- Mid-operation reset: pull `rst` low between edges with `wfill`=9 → all outputs 0 immediately, before the next edge.
